// File: rtl/usb_ram_port_arbiter_pkg.sv
// Shared constants and types for the USB packet RAM port B arbiter.
// Holds the RAM geometry, the CPU IO window base and the grant-owner encoding.
package usb_ram_port_arbiter_pkg;

    localparam int          USB_RAM_ADDR_W   = 8;
    localparam int          USB_RAM_DATA_W   = 32;
    localparam logic [31:0] USB_CPU_WIN_BASE = 32'hC100_0000;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_STR = 1'b1
    } gnt_owner_e;

    // True when a CPU bus address falls inside the 64 KiB USB RAM window.
    function automatic logic in_cpu_window(input logic [31:0] bus_addr);
        return bus_addr[31:16] == USB_CPU_WIN_BASE[31:16];
    endfunction

endpackage

// File: rtl/usb_ram_port_arbiter.sv
// Shares USB packet RAM port B between the CPU IO bus and the streaming engine.
// Alternates priority under contention so neither side waits more than one foreign grant.
module usb_ram_port_arbiter
    import usb_ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = USB_RAM_ADDR_W,
    parameter int DATA_W = USB_RAM_DATA_W
) (
    input  logic                clk_48,
    input  logic                rst_n,
    input  logic                cpu_strobe,
    input  logic                cpu_write,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W/8-1:0] cpu_be,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_ready,
    input  logic                str_req,
    input  logic                str_write,
    input  logic [ADDR_W-1:0]   str_addr,
    input  logic [DATA_W-1:0]   str_wdata,
    output logic                str_gnt,
    output logic [DATA_W-1:0]   str_rdata,
    output logic                str_rvalid,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    input  logic [DATA_W-1:0]   ram_dout
);

    localparam int BE_W = DATA_W / 8;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } cpu_req_t;

    logic              cpu_pend;
    cpu_req_t          cpu_req_q;
    gnt_owner_e        last_grant;
    logic [ADDR_W-1:0] addr_hold;
    logic              issue_cpu;
    logic              issue_str;

    // Issue is gated by rst_n so the RAM port stays quiet for the whole reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        issue_cpu = 1'b0;
        issue_str = 1'b0;
        if (rst_n) begin
            if (cpu_pend && str_req) begin
                issue_cpu = (last_grant == GNT_STR);
                issue_str = (last_grant == GNT_CPU);
            end else begin
                issue_cpu = cpu_pend;
                issue_str = str_req;
            end
        end
    end

    always_comb begin
        ram_we   = '0;
        ram_addr = addr_hold;
        ram_din  = '0;
        str_gnt  = 1'b0;
        if (issue_cpu) begin
            ram_addr = cpu_req_q.addr;
            ram_we   = cpu_req_q.write ? cpu_req_q.be : '0;
            ram_din  = cpu_req_q.wdata;
        end else if (issue_str) begin
            ram_addr = str_addr;
            ram_we   = {BE_W{str_write}};
            ram_din  = str_wdata;
            str_gnt  = 1'b1;
        end
    end

    // RAM read data is synchronous, so both requesters see it the cycle after issue.
    assign cpu_rdata = ram_dout;
    assign str_rdata = ram_dout;

    // NOTE: state flops use non-blocking assignments and an async reset; the RAM array itself is never reset.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            cpu_pend   <= 1'b0;
            cpu_req_q  <= '0;
            last_grant <= GNT_CPU;
            addr_hold  <= '0;
            cpu_ready  <= 1'b0;
            str_rvalid <= 1'b0;
        end else begin
            cpu_ready  <= issue_cpu;
            str_rvalid <= issue_str && !str_write;
            if (issue_cpu) begin
                last_grant <= GNT_CPU;
            end else if (issue_str) begin
                last_grant <= GNT_STR;
            end
            if (issue_cpu || issue_str) begin
                addr_hold <= ram_addr;
            end
            // A strobe while a request is still pending is dropped.
            if (cpu_strobe && !cpu_pend) begin
                cpu_pend  <= 1'b1;
                cpu_req_q <= '{write: cpu_write, addr: cpu_addr, be: cpu_be, wdata: cpu_wdata};
            end else if (issue_cpu) begin
                cpu_pend <= 1'b0;
            end
        end
    end

    a_no_strobe_while_pending : assert property (
        @(posedge clk_48) disable iff (!rst_n) !(cpu_strobe && cpu_pend)
    );

endmodule

// File: tb/tb_usb_ram_port_arbiter.sv
// Self-checking bench for usb_ram_port_arbiter: RAM model, queue-based reference model,
// directed literal checks and randomized CPU/streamer traffic.
module tb_usb_ram_port_arbiter;
    import usb_ram_port_arbiter_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk_48 = 1'b0;
    logic          rst_n  = 1'b0;
    logic          cpu_strobe, cpu_write;
    logic [AW-1:0] cpu_addr;
    logic [BW-1:0] cpu_be;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ready;
    logic          str_req, str_write;
    logic [AW-1:0] str_addr;
    logic [DW-1:0] str_wdata, str_rdata;
    logic          str_gnt, str_rvalid;
    logic [BW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    always #10 clk_48 = ~clk_48;

    usb_ram_port_arbiter dut (
        .clk_48(clk_48), .rst_n(rst_n),
        .cpu_strobe(cpu_strobe), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .str_req(str_req), .str_write(str_write), .str_addr(str_addr), .str_wdata(str_wdata),
        .str_gnt(str_gnt), .str_rdata(str_rdata), .str_rvalid(str_rvalid),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Synchronous RAM behind port B: read-before-write, byte-lane writes.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] mem_word;
    always @(posedge clk_48) begin
        mem_word = mem[ram_addr];
        for (int b = 0; b < BW; b++) if (ram_we[b]) mem_word[8*b +: 8] = ram_din[8*b +: 8];
        mem[ram_addr] <= mem_word;
        ram_dout      <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_48);
        #1;
    endtask

    // Reference model: a pending-request queue for the CPU and a reference memory.
    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } creq_t;

    creq_t         m_cpu_q[$];
    creq_t         m_r;
    logic [DW-1:0] ref_mem [256];
    logic          m_last_str, m_ready, m_rvalid, m_cpu_go, m_str_go;
    logic [AW-1:0] m_hold, m_e_addr;
    logic [BW-1:0] m_e_we;
    logic [DW-1:0] m_e_din, m_cpu_rd, m_str_rd;
    int            cyc = 0;
    int            strobe_cyc = -1;
    int            lat;

    always @(negedge clk_48) begin
        if (!rst_n) begin
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_din", ram_din, 0);
            check("rst_str_gnt", str_gnt, 0);
            check("rst_cpu_ready", cpu_ready, 0);
            check("rst_str_rvalid", str_rvalid, 0);
            m_cpu_q.delete();
            m_last_str = 1'b0;
            m_hold     = '0;
            m_ready    = 1'b0;
            m_rvalid   = 1'b0;
            strobe_cyc = -1;
        end else begin
            check("cpu_ready", cpu_ready, m_ready);
            if (m_ready) check("cpu_rdata", cpu_rdata, m_cpu_rd);
            if (cpu_ready) begin
                lat = cyc - strobe_cyc;
                check("cpu_latency_bound", (lat == 2 || lat == 3), 1);
            end
            check("str_rvalid", str_rvalid, m_rvalid);
            if (m_rvalid) check("str_rdata", str_rdata, m_str_rd);

            // Rule: a lone requester wins; with both, the one not served last wins.
            m_cpu_go = (m_cpu_q.size() != 0) && (!str_req || m_last_str);
            m_str_go = str_req && !m_cpu_go;
            m_e_we   = '0;
            m_e_addr = m_hold;
            m_e_din  = '0;
            if (m_cpu_go) begin
                m_r      = m_cpu_q[0];
                m_e_addr = m_r.addr;
                m_e_we   = m_r.write ? m_r.be : '0;
                m_e_din  = m_r.wdata;
            end else if (m_str_go) begin
                m_e_addr = str_addr;
                m_e_we   = str_write ? '1 : '0;
                m_e_din  = str_wdata;
            end
            check("str_gnt", str_gnt, m_str_go);
            check("ram_we", ram_we, m_e_we);
            check("ram_addr", ram_addr, m_e_addr);
            if (m_cpu_go || m_str_go) check("ram_din", ram_din, m_e_din);

            m_ready  = m_cpu_go;
            m_rvalid = m_str_go && !str_write;
            if (m_cpu_go) begin
                m_r = m_cpu_q.pop_front();
                m_cpu_rd = ref_mem[m_r.addr];
                for (int b = 0; b < BW; b++)
                    if (m_r.write && m_r.be[b]) ref_mem[m_r.addr][8*b +: 8] = m_r.wdata[8*b +: 8];
                m_last_str = 1'b0;
                m_hold     = m_r.addr;
            end
            if (m_str_go) begin
                m_str_rd = ref_mem[str_addr];
                if (str_write) ref_mem[str_addr] = str_wdata;
                m_last_str = 1'b1;
                m_hold     = str_addr;
            end
            if (cpu_strobe) begin
                m_cpu_q.push_back('{write: cpu_write, addr: cpu_addr, be: cpu_be, wdata: cpu_wdata});
                strobe_cyc = cyc;
            end
        end
        cyc++;
    end

    // One CPU access from an idle start, with hand-computed expectations.
    task automatic cpu_op(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] be,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
        cpu_strobe = 1'b1;
        cpu_write  = w;
        cpu_addr   = a;
        cpu_be     = be;
        cpu_wdata  = d;
        tick();
        cpu_strobe = 1'b0;
        @(negedge clk_48);
        check("cpu_issue_addr", ram_addr, a);
        check("cpu_issue_we", ram_we, w ? be : 4'b0000);
        tick();
        @(negedge clk_48);
        check("cpu_ready_s2", cpu_ready, 1);
        if (!w) check("cpu_rdata_s2", cpu_rdata, exp_rd);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [DW-1:0] sdata [20];
    int            k;
    logic          str_on, cpu_busy;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        mem[8'h10]     = 32'h1234_5678;
        ref_mem[8'h10] = 32'h1234_5678;
        cpu_strobe = 0; cpu_write = 0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
        str_req = 0; str_write = 0; str_addr = '0; str_wdata = '0;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // CPU write then read back through the byte-enable merge.
        cpu_op(1'b1, 8'h05, 4'b0011, 32'hDEAD_BEEF, 32'h0);
        cpu_op(1'b0, 8'h05, 4'b0000, 32'h0, 32'h0000_BEEF);

        // Streamer read of a preloaded word.
        str_req = 1'b1; str_write = 1'b0; str_addr = 8'h10;
        @(negedge clk_48);
        check("str_gnt_T", str_gnt, 1);
        tick();
        str_req = 1'b0;
        @(negedge clk_48);
        check("str_rvalid_T1", str_rvalid, 1);
        check("str_rdata_T1", str_rdata, 32'h1234_5678);
        tick();

        // Streamer was served last, so a CPU issue beats a one-cycle streamer request.
        cpu_strobe = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h20; cpu_be = 4'hF; cpu_wdata = 32'hA5A5_A5A5;
        tick();
        cpu_strobe = 1'b0;
        str_req = 1'b1; str_write = 1'b1; str_addr = 8'h30; str_wdata = 32'hFFFF_FFFF;
        @(negedge clk_48);
        check("withdraw_no_gnt", str_gnt, 0);
        check("withdraw_cpu_addr", ram_addr, 8'h20);
        tick();
        str_req = 1'b0;
        @(negedge clk_48);
        check("withdraw_cpu_ready", cpu_ready, 1);
        tick();
        tick();
        check("withdraw_no_write", mem[8'h30], 32'h0);

        // Strobe accepted in the same cycle the previous ready pulses.
        cpu_strobe = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h60; cpu_be = 4'hF; cpu_wdata = 32'hCAFE_F00D;
        tick();
        cpu_strobe = 1'b0;
        tick();
        cpu_strobe = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h60;
        @(negedge clk_48);
        check("b2b_ready_first", cpu_ready, 1);
        tick();
        cpu_strobe = 1'b0;
        tick();
        @(negedge clk_48);
        check("b2b_ready_second", cpu_ready, 1);
        check("b2b_rdata", cpu_rdata, 32'hCAFE_F00D);
        tick();

        // Contention: continuous streamer writes, CPU strobing every third cycle.
        for (int i = 0; i < 20; i++) sdata[i] = $urandom;
        k = 0;
        for (int n = 0; n < 200 && k < 20; n++) begin
            str_req    = 1'b1;
            str_write  = 1'b1;
            str_addr   = 8'h40 + 8'(k);
            str_wdata  = sdata[k];
            cpu_strobe = (n % 3 == 0);
            cpu_write  = 1'($urandom);
            cpu_addr   = 8'h80 + 8'($urandom_range(0, 15));
            cpu_be     = 4'($urandom);
            cpu_wdata  = $urandom;
            @(negedge clk_48);
            if (str_gnt) k++;
            tick();
        end
        str_req = 1'b0;
        cpu_strobe = 1'b0;
        check("stream_count", k, 20);
        repeat (4) tick();
        for (int i = 0; i < 20; i++) check("stream_word", mem[8'h40 + i], sdata[i]);

        // Randomized traffic with withdrawals.
        str_on = 1'b0;
        cpu_busy = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!str_on) begin
                if ($urandom_range(0, 1) == 1) begin
                    str_on = 1'b1; str_req = 1'b1; str_write = 1'($urandom);
                    str_addr = 8'($urandom); str_wdata = $urandom;
                end else begin
                    str_req = 1'b0;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                str_on = 1'b0; str_req = 1'b0;
            end
            cpu_strobe = !cpu_busy && ($urandom_range(0, 2) == 0);
            if (cpu_strobe) begin
                cpu_busy = 1'b1; cpu_write = 1'($urandom); cpu_addr = 8'($urandom);
                cpu_be = 4'($urandom); cpu_wdata = $urandom;
            end
            @(negedge clk_48);
            if (str_gnt) str_on = 1'b0;
            if (cpu_ready) cpu_busy = 1'b0;
            tick();
        end
        str_req = 1'b0;
        cpu_strobe = 1'b0;
        repeat (4) tick();

        // Reset while a CPU request is pending and a streamer read is in flight.
        str_req = 1'b1; str_write = 1'b0; str_addr = 8'h10;
        cpu_strobe = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h70; cpu_be = 4'hF; cpu_wdata = 32'h1111_2222;
        tick();
        str_req = 1'b0;
        cpu_strobe = 1'b0;
        rst_n = 1'b0;
        @(negedge clk_48);
        check("rst_mid_ready", cpu_ready, 0);
        check("rst_mid_rvalid", str_rvalid, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_48);
            check("post_rst_no_ready", cpu_ready, 0);
            tick();
        end
        cpu_op(1'b1, 8'h71, 4'b1100, 32'h89AB_CDEF, 32'h0);
        cpu_op(1'b0, 8'h71, 4'b0000, 32'h0, {16'h89AB, mem[8'h71][15:0]});

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
